// File: rtl/audio_pkg.sv
// Shared definitions for the audio processing chain: frame geometry,
// sample width, the FFT configuration word and the sequencer state type.
package audio_pkg;

    localparam int          FRAME_LOG2  = 10;
    localparam int          SAMPLE_W    = 16;
    localparam logic [15:0] FFT_CFG_FWD = 16'h0001;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_CONFIG,
        SEQ_STREAM,
        SEQ_DONE
    } seq_state_t;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry FIFO with an AXI-Stream style output side. The output data
// comes straight from a register, so it stays stable while the consumer
// stalls. The occupancy is exported so that the producer can throttle
// itself against reads that are already in flight.
module stream_skid2 #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    output logic [1:0]   occupancy_o,
    output logic         pop_o,
    output logic         out_tvalid_o,
    input  logic         out_tready_i,
    output logic [W-1:0] out_tdata_o
);

    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;

    assign occupancy_o  = count_q;
    assign out_tvalid_o = (count_q != 2'd0);
    assign pop_o        = out_tvalid_o && out_tready_i;

    // One storage register per entry, written when the write pointer selects it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [W-1:0] entry_q;
        always_ff @(posedge clock) begin
            if (reset) begin
                entry_q <= '0;
            end else if (push_i && (wr_ptr_q == 1'(gi))) begin
                entry_q <= push_data_i;
            end
        end
    end

    assign out_tdata_o = rd_ptr_q ? g_entry[1].entry_q : g_entry[0].entry_q;

    // Pointer and occupancy bookkeeping; a flush empties the FIFO at once.
    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_o) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_o};
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Streams one frame from the sample BRAM into the FFT core: a config word
// first, then every sample in address order with tlast on the final one.
// The 1-cycle BRAM latency is hidden by a 2-entry skid FIFO so the stream
// runs at one sample per cycle and tolerates arbitrary back-pressure.
module fft_frame_sequencer
    import audio_pkg::*;
#(
    parameter int          ADDR_W   = FRAME_LOG2,
    parameter int          DATA_W   = SAMPLE_W,
    parameter logic [15:0] CFG_WORD = FFT_CFG_FWD
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              buf_en,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [DATA_W-1:0] buf_dout,
    output logic [15:0]       cfg_tdata,
    output logic              cfg_tvalid,
    input  logic              cfg_tready,
    output logic [31:0]       data_tdata,
    output logic              data_tvalid,
    input  logic              data_tready,
    output logic              data_tlast,
    input  logic              ev_tlast_unexpected,
    input  logic              ev_tlast_missing,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Counters carry one extra bit so "all issued" is distinct from address 0.
    localparam logic [ADDR_W:0] FRAME_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST_IDX  = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);

    seq_state_t      state_q, state_d;
    logic [ADDR_W:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_W:0] tx_cnt_q, tx_cnt_d;
    logic            inflight_q;
    logic            error_q, error_d;

    logic              start_accept;
    logic [1:0]        fifo_occ;
    logic              fifo_pop;
    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_data;
    logic [1:0]        pending;
    logic              issue;
    logic              last_hs;

    assign start_accept = (state_q == SEQ_IDLE) && start;

    // Entries still owed to the FIFO after this cycle's pop. Counting the pop
    // lets a new read go out every cycle while the consumer keeps up.
    assign pending = fifo_occ - {1'b0, fifo_pop} + {1'b0, inflight_q};
    assign issue   = (state_q == SEQ_STREAM) && (rd_cnt_q < FRAME_LEN) && (pending < 2'd2);
    assign last_hs = fifo_pop && (tx_cnt_q == LAST_IDX);

    stream_skid2 #(
        .W(DATA_W)
    ) u_skid (
        .clock        (clock),
        .reset        (reset),
        .flush_i      (start_accept),
        .push_i       (inflight_q),
        .push_data_i  (buf_dout),
        .occupancy_o  (fifo_occ),
        .pop_o        (fifo_pop),
        .out_tvalid_o (fifo_valid),
        .out_tready_i (data_tready),
        .out_tdata_o  (fifo_data)
    );

    // Frame sequencing: config word, sample stream, completion pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE:   if (start)      state_d = SEQ_CONFIG;
            SEQ_CONFIG: if (cfg_tready) state_d = SEQ_STREAM;
            SEQ_STREAM: if (last_hs)    state_d = SEQ_DONE;
            SEQ_DONE:                   state_d = SEQ_IDLE;
            default:                    state_d = SEQ_IDLE;
        endcase
    end

    // Read and send counters restart with every accepted frame.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        tx_cnt_d = tx_cnt_q;
        if (start_accept) begin
            rd_cnt_d = '0;
            tx_cnt_d = '0;
        end else begin
            if (issue)    rd_cnt_d = rd_cnt_q + ONE;
            if (fifo_pop) tx_cnt_d = tx_cnt_q + ONE;
        end
    end

    // Sticky framing error: armed only while busy, wiped by a new frame.
    always_comb begin
        error_d = error_q;
        if (start_accept) begin
            error_d = 1'b0;
        end else if ((state_q != SEQ_IDLE) && (ev_tlast_unexpected || ev_tlast_missing)) begin
            error_d = 1'b1;
        end
    end

    // State, counters, in-flight flag and error register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= SEQ_IDLE;
            rd_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            inflight_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            inflight_q <= issue;
            error_q    <= error_d;
        end
    end

    assign buf_en      = issue;
    assign buf_addr    = rd_cnt_q[ADDR_W-1:0];
    assign cfg_tdata   = CFG_WORD;
    assign cfg_tvalid  = (state_q == SEQ_CONFIG);
    assign data_tvalid = fifo_valid;
    assign data_tdata  = {{(32 - DATA_W){1'b0}}, fifo_data};
    assign data_tlast  = fifo_valid && (tx_cnt_q == LAST_IDX);
    assign busy        = (state_q != SEQ_IDLE);
    assign done        = (state_q == SEQ_DONE);
    assign error       = error_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: ramp-filled BRAM model, per-frame
// scenarios (nominal, random back-pressure, config stall, ignored start,
// framing events, mid-frame reset) and a negedge monitor on the streams.
module tb_fft_frame_sequencer;

    localparam int N = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        buf_en;
    logic [9:0]  buf_addr;
    logic [15:0] buf_dout;
    logic [15:0] cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready;
    logic [31:0] data_tdata;
    logic        data_tvalid;
    logic        data_tready;
    logic        data_tlast;
    logic        ev_tlast_unexpected;
    logic        ev_tlast_missing;
    logic        busy;
    logic        done;
    logic        error;

    fft_frame_sequencer dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .buf_en              (buf_en),
        .buf_addr            (buf_addr),
        .buf_dout            (buf_dout),
        .cfg_tdata           (cfg_tdata),
        .cfg_tvalid          (cfg_tvalid),
        .cfg_tready          (cfg_tready),
        .data_tdata          (data_tdata),
        .data_tvalid         (data_tvalid),
        .data_tready         (data_tready),
        .data_tlast          (data_tlast),
        .ev_tlast_unexpected (ev_tlast_unexpected),
        .ev_tlast_missing    (ev_tlast_missing),
        .busy                (busy),
        .done                (done),
        .error               (error)
    );

    always #5 clock = ~clock;

    // Ramp-filled BRAM with one cycle of read latency.
    initial begin
        buf_dout = 16'h0;
        forever begin
            @(posedge clock);
            if (buf_en) buf_dout <= {6'b0, buf_addr};
        end
    end

    int cyc = 0;
    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor state, restarted by the main sequence at each start pulse.
    int          t0 = 0;
    int          rx_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          tlast_cyc = -1;
    int          stall_cnt = 0;
    int          first_valid_cyc = -1;
    int          first_en_cyc = -1;
    int          hs_cfg = 0;
    logic [31:0] first_en_addr = 0;
    bit          cfg_seen = 0;
    bit          err_at_done = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = 0;
    logic        prev_last = 0;

    initial forever begin
        @(negedge clock);
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", data_tvalid, 1);
                chk("hold_data", data_tdata, prev_data);
                chk("hold_last", data_tlast, prev_last);
            end
            if (buf_en) begin
                chk("en_after_cfg", cfg_seen, 1);
                if (first_en_cyc < 0) begin
                    first_en_cyc  = cyc - t0;
                    first_en_addr = {22'b0, buf_addr};
                end
            end
            if (cfg_tvalid && cfg_tready) begin
                hs_cfg++;
                cfg_seen = 1;
            end
            if (data_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc - t0;
            if (data_tvalid && data_tready) begin
                chk("sample", data_tdata, rx_cnt);
                chk("tlast", data_tlast, rx_cnt == N - 1);
                if (data_tlast) tlast_cyc = cyc - t0;
                rx_cnt++;
            end
            if (data_tvalid && !data_tready) stall_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc    = cyc - t0;
                err_at_done = error;
            end
            prev_stall = data_tvalid && !data_tready;
            prev_data  = data_tdata;
            prev_last  = data_tlast;
        end
    end

    task automatic clear_monitor();
        rx_cnt = 0; done_cnt = 0; done_cyc = -1; tlast_cyc = -1; stall_cnt = 0;
        first_valid_cyc = -1; first_en_cyc = -1; hs_cfg = 0; cfg_seen = 0;
        err_at_done = 0; first_en_addr = 32'hFFFF_FFFF;
    endtask

    // One full frame. ev_kind: 0 none, 1 tlast_missing, 2 tlast_unexpected.
    task automatic run_frame(input string name, input bit rand_ready, input int cfg_low,
                             input bit poke_start, input int ev_kind, input int ev_at,
                             input bit exp_err);
        int k;
        bit ok;
        clear_monitor();
        start       = 1'b1;
        cfg_tready  = (cfg_low == 0);
        data_tready = 1'b1;
        t0          = cyc;
        k  = 1;
        ok = 0;
        tick();
        while (k < 6000) begin
            if (k == 1) begin
                chk({name, "_cfg_valid_c1"}, cfg_tvalid, 1);
                chk({name, "_busy_c1"}, busy, 1);
                chk({name, "_err_clear_c1"}, error, 0);
            end
            if (done_cnt > 0 && !busy) begin
                ok = 1;
                break;
            end
            start               = poke_start && (k == 600);
            cfg_tready          = (k > cfg_low);
            data_tready         = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            ev_tlast_missing    = (ev_kind == 1) && (k == ev_at);
            ev_tlast_unexpected = (ev_kind == 2) && (k == ev_at);
            tick();
            k++;
        end
        start = 1'b0; ev_tlast_missing = 1'b0; ev_tlast_unexpected = 1'b0;
        data_tready = 1'b1;
        chk({name, "_timeout"}, ok, 1);
        chk({name, "_samples"}, rx_cnt, N);
        chk({name, "_done_count"}, done_cnt, 1);
        chk({name, "_cfg_hs"}, hs_cfg, 1);
        chk({name, "_first_en_cyc"}, first_en_cyc, 2 + cfg_low);
        chk({name, "_first_en_addr"}, first_en_addr, 0);
        chk({name, "_first_valid_cyc"}, first_valid_cyc, 4 + cfg_low);
        chk({name, "_done_cyc"}, done_cyc, 1028 + cfg_low + stall_cnt);
        chk({name, "_tlast_cyc"}, tlast_cyc, 1027 + cfg_low + stall_cnt);
        chk({name, "_busy_fall"}, k, done_cyc + 1);
        chk({name, "_err_at_done"}, err_at_done, exp_err);
        $display("frame %s: samples %0d done_cyc %0d stalls %0d error %0b",
                 name, rx_cnt, done_cyc, stall_cnt, err_at_done);
    endtask

    initial begin
        int w;
        reset = 1'b1; start = 1'b0; cfg_tready = 1'b0; data_tready = 1'b1;
        ev_tlast_unexpected = 1'b0; ev_tlast_missing = 1'b0;
        repeat (3) tick();
        chk("rst_buf_en", buf_en, 0);
        chk("rst_buf_addr", buf_addr, 0);
        chk("rst_cfg_tvalid", cfg_tvalid, 0);
        chk("rst_cfg_tdata", cfg_tdata, 16'h0001);
        chk("rst_data_tvalid", data_tvalid, 0);
        chk("rst_data_tlast", data_tlast, 0);
        chk("rst_data_tdata", data_tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        reset = 1'b0;
        repeat (2) tick();

        run_frame("nominal", 0, 0, 0, 0, 0, 0);
        tick();
        run_frame("rand_ready", 1, 0, 0, 0, 0, 0);
        tick();
        run_frame("cfg_stall", 0, 5, 0, 0, 0, 0);
        tick();
        run_frame("mid_start", 0, 0, 1, 0, 0, 0);
        tick();
        run_frame("ev_missing", 0, 0, 0, 1, 300, 1);
        chk("err_sticky_idle", error, 1);
        tick();
        run_frame("after_error", 0, 0, 0, 0, 0, 0);
        tick();
        run_frame("ev_on_last", 0, 0, 0, 2, 1027, 1);
        tick();

        // Partial frame interrupted by reset around sample 500.
        clear_monitor();
        start = 1'b1; cfg_tready = 1'b1; data_tready = 1'b1; t0 = cyc;
        tick();
        start = 1'b0;
        w = 0;
        while (rx_cnt < 500 && w < 2000) begin
            tick();
            w++;
        end
        chk("rst_mid_reached_500", rx_cnt >= 500, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_tvalid", data_tvalid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_error", error, 0);
        $display("frame reset_mid: interrupted after %0d samples", rx_cnt);
        repeat (2) tick();
        run_frame("after_reset", 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
